// File: rtl/dmem_pkg.sv
// Shared types and constants for the multi-cycle data-memory responder.
package dmem_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  localparam int unsigned LAT_CNT_W = 4;
  localparam logic [1:0]  ALIGN_MASK = 2'b11;

  // Word access is illegal if misaligned or if any byte-address bit above the array is set.
  function automatic logic addr_err(input logic [31:0] addr, input int unsigned aw);
    return ((addr[1:0] & ALIGN_MASK) != 2'b00) || ((addr >> (aw + 32'd2)) != 32'd0);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x 32 word storage: one synchronous write port, one asynchronous read port.
module dmem_array #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [31:0]       wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/dmem_responder.sv
// MEM-stage data-memory responder: accepts one load/store, waits LATENCY cycles,
// then pulses a registered ack with read data while stalling the pipeline.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned LATENCY = 2,
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned ADDR_W  = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        ack_o,
  output logic        err_o,
  output logic        stall_o
);

  state_e                 state_q;
  logic [LAT_CNT_W-1:0]   cnt_q;
  logic                   we_q;
  logic [31:0]            addr_q;
  logic [31:0]            wdata_q;
  logic                   ack_q;
  logic                   err_q;
  logic [31:0]            rdata_q;

  logic                   go_resp_d;
  logic                   acc_we_d;
  logic [31:0]            acc_addr_d;
  logic [31:0]            acc_wdata_d;
  logic                   acc_err_d;
  logic                   mem_we_d;
  logic [31:0]            mem_rdata;

  // With LATENCY == 1 the access happens on the accepting edge, before the
  // request latches are loaded, so operands come straight from the inputs.
  always_comb begin
    go_resp_d = 1'b0;
    case (state_q)
      S_IDLE:  go_resp_d = req_i && (LATENCY == 32'd1);
      S_WAIT:  go_resp_d = (cnt_q == LAT_CNT_W'(1));
      default: go_resp_d = 1'b0;
    endcase
    acc_we_d    = (state_q == S_IDLE) ? we_i    : we_q;
    acc_addr_d  = (state_q == S_IDLE) ? addr_i  : addr_q;
    acc_wdata_d = (state_q == S_IDLE) ? wdata_i : wdata_q;
    acc_err_d   = addr_err(acc_addr_d, ADDR_W);
    mem_we_d    = go_resp_d && acc_we_d && !acc_err_d;
  end

  dmem_array #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_array (
    .clk_i  (clk_i),
    .we_i   (mem_we_d),
    .waddr_i(acc_addr_d[ADDR_W+1:2]),
    .wdata_i(acc_wdata_d),
    .raddr_i(acc_addr_d[ADDR_W+1:2]),
    .rdata_o(mem_rdata)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      ack_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_i) begin
            we_q    <= we_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
            cnt_q   <= LAT_CNT_W'(LATENCY - 32'd1);
            state_q <= (LATENCY > 32'd1) ? S_WAIT : S_RESP;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q - LAT_CNT_W'(1);
          if (go_resp_d) state_q <= S_RESP;
        end
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
      if (go_resp_d) begin
        ack_q   <= 1'b1;
        err_q   <= acc_err_d;
        rdata_q <= acc_err_d ? '0 : (acc_we_d ? acc_wdata_d : mem_rdata);
      end
    end
  end

  assign rdata_o = rdata_q;
  assign ack_o   = ack_q;
  assign err_o   = err_q;
  assign stall_o = req_i & ~ack_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder at LATENCY 1, 2 and 4 against a word-array model.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        req   [3];
  logic        we    [3];
  logic [31:0] addr  [3];
  logic [31:0] wdata [3];
  logic [31:0] rdata [3];
  logic        ack   [3];
  logic        err   [3];
  logic        stall [3];

  dmem_responder #(.LATENCY(1), .DEPTH(256), .ADDR_W(8)) u_l1 (
    .clk_i(clk), .rst_i(rst_n), .req_i(req[0]), .we_i(we[0]), .addr_i(addr[0]),
    .wdata_i(wdata[0]), .rdata_o(rdata[0]), .ack_o(ack[0]), .err_o(err[0]), .stall_o(stall[0]));
  dmem_responder #(.LATENCY(2), .DEPTH(256), .ADDR_W(8)) u_l2 (
    .clk_i(clk), .rst_i(rst_n), .req_i(req[1]), .we_i(we[1]), .addr_i(addr[1]),
    .wdata_i(wdata[1]), .rdata_o(rdata[1]), .ack_o(ack[1]), .err_o(err[1]), .stall_o(stall[1]));
  dmem_responder #(.LATENCY(4), .DEPTH(256), .ADDR_W(8)) u_l4 (
    .clk_i(clk), .rst_i(rst_n), .req_i(req[2]), .we_i(we[2]), .addr_i(addr[2]),
    .wdata_i(wdata[2]), .rdata_o(rdata[2]), .ack_o(ack[2]), .err_o(err[2]), .stall_o(stall[2]));

  logic [31:0] mem_m [3][256];
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int ack_at  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat(input int k);
    return (k == 0) ? 1 : (k == 1) ? 2 : 4;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One complete transaction on instance k; optionally scrambles inputs in cycle 1.
  task automatic do_txn(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic chg, input logic [31:0] a_alt);
    logic        e;
    logic [31:0] exp_r;
    logic [7:0]  idx;
    int          n;
    n     = lat(k);
    idx   = a[9:2];
    e     = (a % 4 != 0) || (a >= 32'd1024);
    exp_r = e ? 32'd0 : (w ? d : mem_m[k][idx]);
    if (!e && w) mem_m[k][idx] = d;
    @(negedge clk);
    req[k] = 1'b1; we[k] = w; addr[k] = a; wdata[k] = d;
    #1;
    check_eq("stall_c0", 32'(stall[k]), 32'd1);
    check_eq("ack_c0", 32'(ack[k]), 32'd0);
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      if (c < n) begin
        check_eq("stall_wait", 32'(stall[k]), 32'd1);
        check_eq("ack_wait", 32'(ack[k]), 32'd0);
        if (chg && c == 1) begin
          addr[k] = a_alt; we[k] = ~w; wdata[k] = ~d;
        end
      end else begin
        check_eq("ack", 32'(ack[k]), 32'd1);
        check_eq("err", 32'(err[k]), 32'(e));
        check_eq("rdata", rdata[k], exp_r);
        check_eq("stall_ack", 32'(stall[k]), 32'd0);
        ack_at = cyc;
      end
    end
    req[k] = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t1;
    logic [31:0] a;
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req[k] = 1'b0; we[k] = 1'b0; addr[k] = '0; wdata[k] = '0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check_eq("rst_ack", 32'(ack[k]), 32'd0);
      check_eq("rst_err", 32'(err[k]), 32'd0);
      check_eq("rst_rdata", rdata[k], 32'd0);
      check_eq("rst_stall", 32'(stall[k]), 32'd0);
    end
    rst_n = 1'b1;

    // Initialise words 0..31 of each instance through stores; word 5 is the known pattern.
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 32; i++)
        do_txn(k, 1'b1, 32'(i) << 2, (i == 5) ? 32'hDEADBEEF : $urandom, 1'b0, '0);

    for (int k = 0; k < 3; k++) begin
      do_txn(k, 1'b0, 32'h14, '0, 1'b0, '0);
      check_eq("load_w5", mem_m[k][5], 32'hDEADBEEF);
      do_txn(k, 1'b1, 32'h40, 32'h12345678, 1'b0, '0);
      t1 = ack_at;
      do_txn(k, 1'b0, 32'h40, '0, 1'b0, '0);
      check_eq("ack_gap", 32'(ack_at - t1), 32'(lat(k) + 1));
      do_txn(k, 1'b1, 32'h42, 32'hCAFEF00D, 1'b0, '0);
      do_txn(k, 1'b0, 32'h40, '0, 1'b0, '0);
      do_txn(k, 1'b0, 32'h400, '0, 1'b0, '0);
      do_txn(k, 1'b0, 32'h14, '0, 1'b1, 32'h18);
    end

    // Reset during WAIT on the LATENCY=4 instance: the store must vanish.
    @(negedge clk);
    req[2] = 1'b1; we[2] = 1'b1; addr[2] = 32'h08; wdata[2] = 32'hAAAA5555;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0; req[2] = 1'b0;
    #1;
    check_eq("rst_mid_ack", 32'(ack[2]), 32'd0);
    check_eq("rst_mid_err", 32'(err[2]), 32'd0);
    check_eq("rst_mid_rdata", rdata[2], 32'd0);
    check_eq("rst_mid_stall", 32'(stall[2]), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("rst_no_ack", 32'(ack[2]), 32'd0);
    end
    do_txn(2, 1'b0, 32'h08, '0, 1'b0, '0);

    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 40; i++) begin
        a = 32'($urandom_range(0, 31)) << 2;
        case ($urandom_range(0, 7))
          0:       a = a | 32'($urandom_range(1, 3));
          1:       a = a | (32'($urandom_range(1, 4194303)) << 10);
          default: ;
        endcase
        do_txn(k, 1'($urandom_range(0, 1)), a, $urandom, 1'($urandom_range(0, 1)), $urandom);
      end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
